mem_port_arbiter: RTL and testbench

- Shares the single instruction/data memory port between two requesters: the fetch stage (read-only) and the load/store path (read/write).
- Sits between fetch, the memory stage and the `memory` instance.
- Arbitrates with fixed data priority and a starvation limit for fetch.
- Tracks one outstanding read of fixed latency, range-checks addresses and returns each read response to the requester that issued it.

---
 rtl/mem_arb_pkg.sv | 33 +++
 rtl/mem_arb_tracker.sv | 66 ++++++
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and address-check helpers for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_e;
    typedef enum logic [0:0] {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            SZ_W:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Done at 64 bits so an access running past the top of the address space cannot wrap into range.
    function automatic logic addr_ok(input logic [63:0] addr, input logic [1:0] size,
                                     input logic [63:0] base, input logic [63:0] span);
        logic aligned;
        case (size)
            SZ_B:    aligned = 1'b1;
            SZ_H:    aligned = ~addr[0];
            SZ_W:    aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        return aligned && (addr >= base) && ((addr + 64'(size_bytes(size))) <= (base + span));
    endfunction

endpackage

// File: rtl/mem_arb_tracker.sv
// Outstanding-read tracker: owns the IDLE/WAIT sequencing and routes each response to its requester.
//   state | meaning
//   IDLE  | no read in flight; accept window open every cycle
//   WAIT  | read in flight for owner; cnt runs 1..LATENCY, window opens at cnt == LATENCY
module mem_arb_tracker
    import mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   grant,
    input  owner_e grant_owner,
    input  logic   grant_read,
    input  logic   grant_err,
    output logic   accept,
    output logic   busy,
    output logic   if_rvalid,
    output logic   if_err,
    output logic   dm_rvalid,
    output logic   dm_err
);
    localparam int CW = $clog2(LATENCY + 1);

    state_e          state;
    owner_e          owner;
    owner_e          err_owner;
    logic            err_pend;
    logic [CW-1:0]   cnt;
    logic            complete;

    always_comb begin
        complete  = (state == WAIT) && (cnt == CW'(LATENCY));
        accept    = rst && ((state == IDLE) || complete);
        busy      = (state == WAIT);
        if_err    = err_pend && (err_owner == OWN_IF);
        dm_err    = err_pend && (err_owner == OWN_DM);
        if_rvalid = (complete && (owner == OWN_IF)) || if_err;
        dm_rvalid = (complete && (owner == OWN_DM)) || dm_err;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            err_owner <= OWN_IF;
            err_pend  <= 1'b0;
            cnt       <= '0;
        end else begin
            // Rejected requests never occupy the port; their error answer is due next cycle.
            err_pend  <= grant && grant_err;
            err_owner <= grant_owner;
            if (grant && grant_read) begin
                state <= WAIT;
                owner <= grant_owner;
                cnt   <= CW'(1);
            end else if ((state == WAIT) && !complete) begin
                cnt <= cnt + CW'(1);
            end else begin
                state <= IDLE;
                cnt   <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between fetch and load/store: fixed data priority,
// a fetch starvation limit, and range/alignment checking of every granted access.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned        AWIDTH         = 32,
    parameter int unsigned        DWIDTH         = 32,
    parameter logic [AWIDTH-1:0]  BASE_ADDR      = 32'h01000000,
    parameter int unsigned        MEM_BYTES      = 1048576,
    parameter int unsigned        LATENCY        = 1,
    parameter int unsigned        MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_ready_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,
    output logic              if_err_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [1:0]        dm_size_i,
    input  logic [AWIDTH-1:0] dm_addr_i,
    input  logic [DWIDTH-1:0] dm_wdata_i,
    output logic              dm_ready_o,
    output logic              dm_rvalid_o,
    output logic [DWIDTH-1:0] dm_rdata_o,
    output logic              dm_err_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic [1:0]        mem_size_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i,
    output logic              busy_o
);
    localparam int SW = $clog2(MAX_DATA_BURST + 1);

    logic              accept;
    logic              dm_win;
    logic              if_win;
    logic              grant;
    logic              win_we;
    logic              win_ok;
    owner_e            win_owner;
    logic [AWIDTH-1:0] win_addr;
    logic [1:0]        win_size;
    logic [AWIDTH-1:0] addr_q;
    logic [1:0]        size_q;
    logic [DWIDTH-1:0] data_q;
    logic [SW-1:0]     starve_cnt;
    logic              if_rvalid;
    logic              if_err;
    logic              dm_rvalid;
    logic              dm_err;

    always_comb begin
        dm_win    = accept && dm_req_i && (!if_req_i || (starve_cnt < SW'(MAX_DATA_BURST)));
        if_win    = accept && if_req_i && !dm_win;
        grant     = dm_win || if_win;
        win_owner = dm_win ? OWN_DM : OWN_IF;
        win_addr  = dm_win ? dm_addr_i : if_addr_i;
        win_size  = dm_win ? dm_size_i : SZ_W;
        win_we    = dm_win && dm_we_i;
        win_ok    = addr_ok(64'(win_addr), win_size, 64'(BASE_ADDR), 64'(MEM_BYTES));
    end

    assign if_ready_o     = if_win;
    assign dm_ready_o     = dm_win;
    assign mem_read_en_o  = grant && win_ok && !win_we;
    assign mem_write_en_o = grant && win_ok && win_we;
    assign mem_addr_o     = grant ? win_addr : addr_q;
    assign mem_size_o     = grant ? win_size : size_q;
    assign mem_data_o     = dm_win ? dm_wdata_i : data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            size_q     <= '0;
            data_q     <= '0;
            starve_cnt <= '0;
        end else begin
            if (grant) begin
                addr_q <= win_addr;
                size_q <= win_size;
            end
            if (dm_win) begin
                data_q <= dm_wdata_i;
            end
            // Only back-to-back data wins against a waiting fetch count toward the burst limit.
            if (!if_req_i || if_win) begin
                starve_cnt <= '0;
            end else if (dm_win && (starve_cnt != SW'(MAX_DATA_BURST))) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

    mem_arb_tracker #(
        .LATENCY (LATENCY)
    ) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .grant       (grant),
        .grant_owner (win_owner),
        .grant_read  (win_ok && !win_we),
        .grant_err   (!win_ok),
        .accept      (accept),
        .busy        (busy_o),
        .if_rvalid   (if_rvalid),
        .if_err      (if_err),
        .dm_rvalid   (dm_rvalid),
        .dm_err      (dm_err)
    );

    assign if_rvalid_o = if_rvalid;
    assign if_err_o    = if_err;
    assign if_rdata_o  = (if_rvalid && !if_err) ? mem_data_i : '0;
    assign dm_rvalid_o = dm_rvalid;
    assign dm_err_o    = dm_err;
    assign dm_rdata_o  = (dm_rvalid && !dm_err) ? mem_data_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_port_arbiter;
    localparam logic [31:0] BASE = 32'h01000000;
    localparam int unsigned MEMB = 1048576;
    localparam int          LAT  = 1;
    localparam int          MAXB = 4;

    logic clk, rst, rst3;
    int   n_cmp = 0, n_bad = 0;

    logic        if_req, if_ready, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_ready, dm_rvalid, dm_err;
    logic [1:0]  dm_size, mem_size;
    logic [31:0] dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd_en, mem_wr_en, busy;

    logic        if_req3, if_ready3, if_rvalid3, if_err3;
    logic [31:0] if_addr3, if_rdata3;
    logic        dm_req3, dm_we3, dm_ready3, dm_rvalid3, dm_err3;
    logic [1:0]  dm_size3, mem_size3;
    logic [31:0] dm_addr3, dm_wdata3, dm_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic        mem_rd_en3, mem_wr_en3, busy3;
    logic [31:0] p0, p1;

    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    typedef struct { int cyc; bit dm; logic [31:0] data; bit err; } rsp_t;
    rsp_t exp_q[$];

    mem_port_arbiter #(.LATENCY(1), .MAX_DATA_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ready_o(if_ready), .if_rvalid_o(if_rvalid),
        .if_rdata_o(if_rdata), .if_err_o(if_err),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_size_i(dm_size), .dm_addr_i(dm_addr),
        .dm_wdata_i(dm_wdata), .dm_ready_o(dm_ready), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
        .dm_err_o(dm_err), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_size_o(mem_size),
        .mem_read_en_o(mem_rd_en), .mem_write_en_o(mem_wr_en), .mem_data_i(mem_rdata), .busy_o(busy));

    mem_port_arbiter #(.LATENCY(3), .MAX_DATA_BURST(4)) dut3 (
        .clk(clk), .rst(rst3),
        .if_req_i(if_req3), .if_addr_i(if_addr3), .if_ready_o(if_ready3), .if_rvalid_o(if_rvalid3),
        .if_rdata_o(if_rdata3), .if_err_o(if_err3),
        .dm_req_i(dm_req3), .dm_we_i(dm_we3), .dm_size_i(dm_size3), .dm_addr_i(dm_addr3),
        .dm_wdata_i(dm_wdata3), .dm_ready_o(dm_ready3), .dm_rvalid_o(dm_rvalid3), .dm_rdata_o(dm_rdata3),
        .dm_err_o(dm_err3), .mem_addr_o(mem_addr3), .mem_data_o(mem_wdata3), .mem_size_o(mem_size3),
        .mem_read_en_o(mem_rd_en3), .mem_write_en_o(mem_wr_en3), .mem_data_i(mem_rdata3), .busy_o(busy3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : (a ^ 32'h5A5A0000);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'h5A5A0000);
    endfunction

    function automatic bit ref_ok(input logic [31:0] a, input logic [1:0] sz);
        longint unsigned la, n;
        if (sz == 2'd3) return 1'b0;
        la = longint'(a);
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        return ((la % n) == 0) && (la >= longint'(BASE)) && ((la + n) <= longint'(BASE) + longint'(MEMB));
    endfunction

    function automatic logic [31:0] gen_addr();
        case ($urandom_range(0, 5))
            0, 1, 2: return BASE + 32'($urandom_range(0, 63) * 4);
            3:       return BASE + MEMB - 32'($urandom_range(0, 8));
            4:       return BASE - 32'($urandom_range(1, 8));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [1:0] gen_size();
        int r = $urandom_range(0, 9);
        return (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
    endfunction

    // Memory models: fixed-latency reads, writes land at the clock edge of the strobe.
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem_rd(mem_addr);
        if (mem_wr_en) mem_arr[mem_addr] = mem_wdata;
    end

    initial begin p0 = '0; p1 = '0; mem_rdata3 = '0; end
    always @(posedge clk) begin
        p0         <= mem_rd_en3 ? mem_rd(mem_addr3) : 32'h0;
        p1         <= p0;
        mem_rdata3 <= p1;
    end

    task automatic test_reset();
        if_req = 1; dm_req = 1; if_addr = BASE; dm_addr = BASE;
        @(negedge clk);
        n_cmp++;
        if ({if_ready, dm_ready, mem_rd_en, mem_wr_en} !== 4'b0) begin
            n_bad++; $display("FAIL reset_grant: got %b exp 0000", {if_ready, dm_ready, mem_rd_en, mem_wr_en});
        end
        if_req = 0; dm_req = 0;
        repeat (2) @(negedge clk);
        rst = 1; rst3 = 1;
        @(negedge clk);
        n_cmp++;
        if ({if_ready, if_rvalid, if_rdata, if_err, dm_ready, dm_rvalid, dm_rdata, dm_err,
             mem_addr, mem_wdata, mem_size, mem_rd_en, mem_wr_en, busy} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got addr %h data %h busy %b, exp all zero", mem_addr, mem_wdata, busy);
        end
    endtask

    task automatic test_fetch_single();
        @(posedge clk); #1 if_req = 1; if_addr = 32'h01000000;
        @(negedge clk);
        n_cmp++;
        if ({if_ready, mem_rd_en, mem_wr_en} !== 3'b110 || mem_addr !== 32'h01000000 || mem_size !== 2'd2) begin
            n_bad++; $display("FAIL fetch_grant: got rdy/rd/wr %b addr %h size %0d exp 110 01000000 2",
                              {if_ready, mem_rd_en, mem_wr_en}, mem_addr, mem_size);
        end
        @(posedge clk); #1 if_req = 0;
        @(negedge clk);
        n_cmp++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'h00500093 || if_err !== 1'b0) begin
            n_bad++; $display("FAIL fetch_rsp: got v %b d %h e %b exp 1 00500093 0", if_rvalid, if_rdata, if_err);
        end
    endtask

    task automatic test_simultaneous();
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h01000004;
        dm_req = 1; dm_we = 0; dm_size = 2'd2; dm_addr = 32'h01000100;
        @(negedge clk);
        n_cmp++;
        if (dm_ready !== 1'b1 || if_ready !== 1'b0 || mem_addr !== 32'h01000100) begin
            n_bad++; $display("FAIL sim_first: got dm %b if %b addr %h exp 1 0 01000100", dm_ready, if_ready, mem_addr);
        end
        @(posedge clk); #1 dm_req = 0;
        @(negedge clk);
        n_cmp++;
        if (dm_rvalid !== 1'b1 || dm_rdata !== ref_rd(32'h01000100) || if_ready !== 1'b1 || if_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL sim_second: got dmv %b dmd %h ifrdy %b ifv %b exp 1 %h 1 0",
                              dm_rvalid, dm_rdata, if_ready, if_rvalid, ref_rd(32'h01000100));
        end
        @(posedge clk); #1 if_req = 0;
        @(negedge clk);
        n_cmp++;
        if (if_rvalid !== 1'b1 || if_rdata !== ref_rd(32'h01000004) || dm_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL sim_third: got ifv %b ifd %h dmv %b exp 1 %h 0",
                              if_rvalid, if_rdata, dm_rvalid, ref_rd(32'h01000004));
        end
    endtask

    task automatic test_burst();
        bit exp_if;
        @(posedge clk); #1;
        if_req = 1; if_addr = BASE + 32'h40;
        dm_req = 1; dm_we = 0; dm_size = 2'd2; dm_addr = BASE + 32'h80;
        for (int i = 0; i < 10; i++) begin
            exp_if = ((i % (MAXB + 1)) == MAXB);
            @(negedge clk);
            n_cmp++;
            if (if_ready !== exp_if || dm_ready !== !exp_if) begin
                n_bad++; $display("FAIL burst_%0d: got if %b dm %b exp if %b dm %b", i, if_ready, dm_ready, exp_if, !exp_if);
            end
            @(posedge clk); #1;
        end
        if_req = 0; dm_req = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_store();
        @(posedge clk); #1;
        dm_req = 1; dm_we = 1; dm_size = 2'd2; dm_addr = 32'h01000010; dm_wdata = 32'hDEADBEEF;
        if_req = 1; if_addr = 32'h01000010;
        @(negedge clk);
        n_cmp++;
        if ({dm_ready, if_ready, mem_wr_en, mem_rd_en} !== 4'b1010 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h01000010) begin
            n_bad++; $display("FAIL store_grant: got rdy/wr/rd %b data %h addr %h exp 1010 deadbeef 01000010",
                              {dm_ready, if_ready, mem_wr_en, mem_rd_en}, mem_wdata, mem_addr);
        end
        ref_mem[32'h01000010] = 32'hDEADBEEF;
        @(posedge clk); #1 dm_req = 0; dm_we = 0;
        @(negedge clk);
        n_cmp++;
        if (if_ready !== 1'b1 || mem_rd_en !== 1'b1 || mem_wr_en !== 1'b0 || dm_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL store_next: got ifrdy %b rd %b wr %b dmv %b exp 1 1 0 0", if_ready, mem_rd_en, mem_wr_en, dm_rvalid);
        end
        @(posedge clk); #1 if_req = 0;
        @(negedge clk);
        n_cmp++;
        if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEADBEEF || mem_wdata !== 32'hDEADBEEF || mem_wr_en !== 1'b0) begin
            n_bad++; $display("FAIL store_readback: got v %b d %h held %h wr %b exp 1 deadbeef deadbeef 0",
                              if_rvalid, if_rdata, mem_wdata, mem_wr_en);
        end
    endtask

    task automatic test_errors();
        logic [31:0] ta  [10] = '{32'h00FFFFFC, 32'h01000001, 32'h010FFFFC, 32'h010FFFFE, 32'h010FFFFE,
                                  32'h010FFFFF, 32'h01100000, 32'hFFFFFFFF, 32'h01000000, 32'h01000003};
        logic [1:0]  tsz [10] = '{2'd2, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2};
        bit          twe [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        bit          terr[10] = '{1, 1, 0, 1, 0, 0, 1, 1, 1, 1};
        logic [31:0] ed;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            dm_req = 1; dm_addr = ta[i]; dm_size = tsz[i]; dm_we = twe[i]; dm_wdata = 32'h12345678;
            @(negedge clk);
            n_cmp++;
            if (dm_ready !== 1'b1 || mem_rd_en !== (!terr[i] && !twe[i]) || mem_wr_en !== (!terr[i] && twe[i])) begin
                n_bad++; $display("FAIL err_grant_%0d: got rdy %b rd %b wr %b for addr %h", i, dm_ready, mem_rd_en, mem_wr_en, ta[i]);
            end
            @(posedge clk); #1 dm_req = 0; dm_we = 0;
            ed = terr[i] ? 32'h0 : ref_rd(ta[i]);
            @(negedge clk);
            n_cmp++;
            if (dm_rvalid !== (terr[i] || !twe[i]) || dm_err !== terr[i] || dm_rdata !== ed) begin
                n_bad++; $display("FAIL err_rsp_%0d: got v %b e %b d %h exp v %b e %b d %h",
                                  i, dm_rvalid, dm_err, dm_rdata, (terr[i] || !twe[i]), terr[i], ed);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1 if_req3 = 1; if_addr3 = 32'h01000020;
        @(negedge clk);
        n_cmp++;
        if (if_ready3 !== 1'b1 || mem_rd_en3 !== 1'b1) begin
            n_bad++; $display("FAIL l3_grant: got rdy %b rd %b exp 1 1", if_ready3, mem_rd_en3);
        end
        @(posedge clk); #1 if_req3 = 0;
        @(negedge clk);
        n_cmp++;
        if (busy3 !== 1'b1) begin n_bad++; $display("FAIL l3_busy: got %b exp 1", busy3); end
        rst3 = 0; if_req3 = 1; if_addr3 = 32'h01000040;
        #1;
        n_cmp++;
        if ({if_ready3, if_rvalid3, if_rdata3, if_err3, dm_ready3, dm_rvalid3, dm_rdata3, dm_err3,
             mem_addr3, mem_wdata3, mem_size3, mem_rd_en3, mem_wr_en3, busy3} !== '0) begin
            n_bad++; $display("FAIL l3_reset_outputs: got rdy %b busy %b addr %h exp all zero", if_ready3, busy3, mem_addr3);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); if_req3 = 0; rst3 = 1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            n_cmp++;
            if ({if_rvalid3, busy3} !== 2'b00) begin
                n_bad++; $display("FAIL l3_ghost_%0d: got v %b busy %b exp 0 0", j, if_rvalid3, busy3);
            end
        end
        @(posedge clk); #1 if_req3 = 1; if_addr3 = 32'h01000000;
        @(negedge clk);
        n_cmp++;
        if (if_ready3 !== 1'b1 || mem_addr3 !== 32'h01000000) begin
            n_bad++; $display("FAIL l3_regrant: got rdy %b addr %h exp 1 01000000", if_ready3, mem_addr3);
        end
        @(posedge clk); #1 if_req3 = 0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            n_cmp++;
            if (if_rvalid3 !== (j == 3) || busy3 !== (j <= 3) ||
                if_rdata3 !== ((j == 3) ? 32'h00500093 : 32'h0) || if_err3 !== 1'b0) begin
                n_bad++; $display("FAIL l3_rsp_t%0d: got v %b busy %b d %h e %b", j, if_rvalid3, busy3, if_rdata3, if_err3);
            end
        end
    endtask

    task automatic test_random(input int ncyc);
        bit if_pend = 0, dm_pend = 0;
        int cyc = 0, next_free = 0, busy_end = -1, starve = 0;
        bit acc, g_if, g_dm, ok, we, exp_busy, ei_v, ei_e, ed_v, ed_e;
        logic [31:0] a, ei_d, ed_d;
        logic [1:0] sz;
        rsp_t r;
        exp_q.delete();
        if_req = 0; dm_req = 0;
        repeat (3) @(posedge clk);
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            if (!if_pend && $urandom_range(0, 3) != 0) begin if_pend = 1; if_addr = gen_addr(); end
            if (!dm_pend && $urandom_range(0, 3) != 0) begin
                dm_pend = 1; dm_addr = gen_addr(); dm_size = gen_size();
                dm_we = ($urandom_range(0, 2) == 0); dm_wdata = $urandom;
            end
            if_req = if_pend; dm_req = dm_pend;
            @(negedge clk);
            exp_busy = (cyc <= busy_end);
            acc  = (cyc >= next_free);
            g_dm = acc && dm_req && (!if_req || starve < MAXB);
            g_if = acc && if_req && !g_dm;
            n_cmp++;
            if (if_ready !== g_if || dm_ready !== g_dm) begin
                n_bad++; $display("FAIL rnd_grant c%0d: got if %b dm %b exp if %b dm %b", cyc, if_ready, dm_ready, g_if, g_dm);
            end
            ei_v = 0; ei_e = 0; ei_d = '0; ed_v = 0; ed_e = 0; ed_d = '0;
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].cyc == cyc) begin
                    if (exp_q[i].dm) begin ed_v = 1; ed_e = exp_q[i].err; ed_d = exp_q[i].data; end
                    else             begin ei_v = 1; ei_e = exp_q[i].err; ei_d = exp_q[i].data; end
                    exp_q.delete(i);
                end
            end
            n_cmp++;
            if (if_rvalid !== ei_v || if_err !== ei_e || if_rdata !== ei_d) begin
                n_bad++; $display("FAIL rnd_if_rsp c%0d: got v %b e %b d %h exp v %b e %b d %h",
                                  cyc, if_rvalid, if_err, if_rdata, ei_v, ei_e, ei_d);
            end
            n_cmp++;
            if (dm_rvalid !== ed_v || dm_err !== ed_e || dm_rdata !== ed_d) begin
                n_bad++; $display("FAIL rnd_dm_rsp c%0d: got v %b e %b d %h exp v %b e %b d %h",
                                  cyc, dm_rvalid, dm_err, dm_rdata, ed_v, ed_e, ed_d);
            end
            n_cmp++;
            if (busy !== exp_busy) begin n_bad++; $display("FAIL rnd_busy c%0d: got %b exp %b", cyc, busy, exp_busy); end
            if (g_if || g_dm) begin
                a  = g_dm ? dm_addr : if_addr;
                sz = g_dm ? dm_size : 2'd2;
                we = g_dm && dm_we;
                ok = ref_ok(a, sz);
                n_cmp++;
                if (mem_rd_en !== (ok && !we) || mem_wr_en !== (ok && we) || mem_addr !== a || mem_size !== sz ||
                    (ok && we && mem_wdata !== dm_wdata)) begin
                    n_bad++; $display("FAIL rnd_mem c%0d: got rd %b wr %b addr %h size %0d exp rd %b wr %b addr %h size %0d",
                                      cyc, mem_rd_en, mem_wr_en, mem_addr, mem_size, ok && !we, ok && we, a, sz);
                end
                r.dm = g_dm;
                if (!ok) begin
                    r.cyc = cyc + 1; r.data = '0; r.err = 1; exp_q.push_back(r);
                    next_free = cyc + 1;
                end else if (!we) begin
                    r.cyc = cyc + LAT; r.data = ref_rd(a); r.err = 0; exp_q.push_back(r);
                    next_free = cyc + LAT; busy_end = cyc + LAT;
                end else begin
                    ref_mem[a] = dm_wdata;
                    next_free = cyc + 1;
                end
            end else begin
                n_cmp++;
                if ({mem_rd_en, mem_wr_en} !== 2'b00) begin
                    n_bad++; $display("FAIL rnd_idle_strobe c%0d: got %b exp 00", cyc, {mem_rd_en, mem_wr_en});
                end
            end
            if (!if_req || g_if) starve = 0;
            else if (g_dm && starve < MAXB) starve++;
            if (g_if) if_pend = 0;
            if (g_dm) dm_pend = 0;
            cyc++;
        end
        if_req = 0; dm_req = 0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        rst = 0; rst3 = 0;
        if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_size = '0; dm_addr = '0; dm_wdata = '0;
        if_req3 = 0; if_addr3 = '0; dm_req3 = 0; dm_we3 = 0; dm_size3 = '0; dm_addr3 = '0; dm_wdata3 = '0;
        mem_arr[32'h01000000] = 32'h00500093;
        ref_mem[32'h01000000] = 32'h00500093;
        test_reset();
        test_fetch_single();
        test_simultaneous();
        test_burst();
        test_store();
        test_errors();
        test_reset_mid();
        test_random(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
